// File: rtl/ifu_prefetch.sv
// ifu_prefetch: line-based instruction fetch with a prefetch queue.
// Issues 8-byte line reads (several may be in flight), buffers the returned
// lines and hands them to decode one 32-bit instruction at a time.
// A redirect empties the queue. Responses to requests that were already in
// flight are still retired but their data is discarded.
module ifu_prefetch #(
    parameter logic [63:0] PC_START = 64'h8000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst
);
    localparam int QW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    // Instruction PCs are kept without their always-zero byte bits [1:0]
    logic [61:0]    fetch_pc_r;
    logic [CW-1:0]  outst_r;
    logic [CW-1:0]  drop_r;
    logic [61:0]    pend_r [MAX_OUT];
    logic [PW-1:0]  pend_wr_r;
    logic [PW-1:0]  pend_rd_r;
    logic [61:0]    q_pc_r [DEPTH];
    logic [63:0]    q_data_r [DEPTH];
    logic [QW-1:0]  q_head_r;
    logic [QW-1:0]  q_tail_r;
    logic [QW:0]    q_cnt_r;
    logic           lo_done_r;

    logic           accept_s;
    logic           push_s;
    logic           pop_s;
    logic           fire_s;
    logic           slot_s;
    logic           credit_ok_s;
    logic [CW-1:0]  outst_nx_s;
    logic [CW-1:0]  drop_nx_s;
    logic [QW:0]    q_cnt_nx_s;
    logic [1:0]     unused_bits_s;

    // Advance a pending-FIFO pointer; the depth need not be a power of two
    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUT - 1)) begin
            return PW'(0);
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign unused_bits_s = redirect_pc[1:0];

    // A line may only be requested when it is guaranteed a queue slot on return
    assign credit_ok_s   = (32'(outst_r) + 32'(q_cnt_r)) < 32'(DEPTH);
    assign mem_req_valid = !redirect && (outst_r < CW'(MAX_OUT)) && credit_ok_s;
    assign mem_req_addr  = {fetch_pc_r[61:1], 3'b000};
    assign accept_s      = mem_req_valid && mem_req_ready;

    // Only responses to requests issued after the latest redirect enter the queue
    assign push_s = mem_resp_valid && !redirect && (drop_r == CW'(0));

    // The head slot is the upper half when the line was entered at +4 or the lower half is done
    assign slot_s    = q_pc_r[q_head_r][0] | lo_done_r;
    assign out_valid = (q_cnt_r != (QW + 1)'(0)) && !redirect;
    assign out_pc    = {q_pc_r[q_head_r][61:1], slot_s, 2'b00};
    assign out_inst  = slot_s ? q_data_r[q_head_r][63:32] : q_data_r[q_head_r][31:0];
    assign fire_s    = out_valid && out_ready;
    assign pop_s     = fire_s && slot_s;

    // Next values of the in-flight, drop and occupancy counters
    always_comb begin
        outst_nx_s = outst_r;
        drop_nx_s  = drop_r;
        q_cnt_nx_s = q_cnt_r;
        if (accept_s && !mem_resp_valid) begin
            outst_nx_s = outst_r + CW'(1);
        end else if (!accept_s && mem_resp_valid) begin
            outst_nx_s = outst_r - CW'(1);
        end else begin
            outst_nx_s = outst_r;
        end
        if (redirect) begin
            // Nothing is accepted in a redirect cycle, so every remaining request is stale
            drop_nx_s  = outst_nx_s;
            q_cnt_nx_s = (QW + 1)'(0);
        end else begin
            if (mem_resp_valid && (drop_r != CW'(0))) begin
                drop_nx_s = drop_r - CW'(1);
            end else begin
                drop_nx_s = drop_r;
            end
            case ({push_s, pop_s})
                2'b10:   q_cnt_nx_s = q_cnt_r + (QW + 1)'(1);
                2'b01:   q_cnt_nx_s = q_cnt_r - (QW + 1)'(1);
                default: q_cnt_nx_s = q_cnt_r;
            endcase
        end
    end

    // Fetch PC and request bookkeeping counters
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= PC_START[63:2];
            outst_r    <= CW'(0);
            drop_r     <= CW'(0);
        end else begin
            outst_r <= outst_nx_s;
            drop_r  <= drop_nx_s;
            if (redirect) begin
                fetch_pc_r <= redirect_pc[63:2];
            end else if (accept_s) begin
                fetch_pc_r <= {fetch_pc_r[61:1] + 61'd1, 1'b0};
            end
        end
    end

    // Pending FIFO holding the PC of every accepted but unanswered request
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                pend_r[i] <= 62'd0;
            end
            pend_wr_r <= PW'(0);
            pend_rd_r <= PW'(0);
        end else begin
            if (accept_s) begin
                pend_r[pend_wr_r] <= fetch_pc_r;
                pend_wr_r         <= pend_inc(pend_wr_r);
            end
            if (mem_resp_valid) begin
                pend_rd_r <= pend_inc(pend_rd_r);
            end
        end
    end

    // Line queue storage, pointers and head slot tracking
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]   <= 62'd0;
                q_data_r[i] <= 64'd0;
            end
            q_head_r  <= QW'(0);
            q_tail_r  <= QW'(0);
            q_cnt_r   <= (QW + 1)'(0);
            lo_done_r <= 1'b0;
        end else begin
            q_cnt_r <= q_cnt_nx_s;
            if (redirect) begin
                q_head_r  <= QW'(0);
                q_tail_r  <= QW'(0);
                lo_done_r <= 1'b0;
            end else begin
                if (push_s) begin
                    q_pc_r[q_tail_r]   <= pend_r[pend_rd_r];
                    q_data_r[q_tail_r] <= mem_resp_data;
                    q_tail_r           <= q_tail_r + QW'(1);
                end
                if (pop_s) begin
                    q_head_r  <= q_head_r + QW'(1);
                    lo_done_r <= 1'b0;
                end else if (fire_s) begin
                    lo_done_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch: in-order memory model with random latency and
// a reference model of the fetch stream (expected request address stream,
// expected instruction PC stream, epoch-tagged in-flight requests, buffered
// line count) checked every cycle, plus directed redirect/stall sequences.
module tb_ifu_prefetch;
    localparam logic [63:0] PC_START = 64'h8000_0000;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;

    logic        clock = 1'b0;
    logic        rst;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    ifu_prefetch #(.PC_START(PC_START), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    typedef struct {
        logic [63:0] target;
        logic [63:0] exp_req;
        logic [63:0] exp_first;
        logic [63:0] exp_second;
    } redir_vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    logic [63:0] exp_req;
    logic [63:0] exp_pc;
    int          out_cnt;
    int          buf_lines;
    int          epoch;
    mreq_t       memq[$];
    int          last_due;
    int          rsp_ep;

    // stimulus controls
    int          lat_min = 1, lat_max = 1;
    int          p_ready = 100, p_out = 100, p_redir = 0;
    logic        redir_req = 1'b0;
    logic        redir_on_resp = 1'b0;
    logic [63:0] redir_target;

    // observations
    logic [63:0] hs_q[$];
    int          hs_cyc[$];
    logic [63:0] cap_req;
    logic        cap_seen;
    int          acc_total;
    int          hs_total = 0;
    int          max_out_seen;
    int          redir_cyc;
    logic        redir_with_resp;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        logic [31:0] h;
        h = a[31:0] * 32'h9E37_79B9;
        return h ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] rand_target();
        case ($urandom_range(2))
            0:       return {32'($urandom), 32'($urandom)};
            1:       return 64'h8000_0000 + 64'($urandom_range(255));
            default: return 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(255));
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        hs_q.delete();
        hs_cyc.delete();
        cap_seen = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, update the model
    task automatic step();
        mreq_t m;
        logic  exp_rv, exp_ov, acc, hs;
        // drive phase
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        rsp_ep         = -1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            mem_resp_valid = 1'b1;
            mem_resp_data  = {inst_of(m.addr + 64'd4), inst_of(m.addr)};
            rsp_ep         = m.ep;
        end
        mem_req_ready = ($urandom_range(99) < p_ready);
        out_ready     = ($urandom_range(99) < p_out);
        redirect      = 1'b0;
        if (redir_req && (!redir_on_resp || mem_resp_valid)) begin
            redirect    = 1'b1;
            redirect_pc = redir_target;
            redir_req   = 1'b0;
        end else if ($urandom_range(999) < p_redir) begin
            redirect    = 1'b1;
            redirect_pc = rand_target();
        end
        if (redirect) begin
            redir_cyc       = cyc;
            redir_with_resp = mem_resp_valid;
        end
        @(negedge clock);
        // check phase
        exp_rv = !redirect && (out_cnt < MAX_OUT) && (out_cnt + buf_lines < DEPTH);
        exp_ov = (buf_lines > 0) && !redirect;
        chk("req_valid", 64'(mem_req_valid), 64'(exp_rv));
        if (mem_req_valid) chk("req_addr", mem_req_addr, exp_req);
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (out_valid) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_inst", 64'(out_inst), 64'(inst_of(exp_pc)));
        end
        // model update
        acc = mem_req_valid && mem_req_ready;
        hs  = out_valid && out_ready;
        if (redirect) begin
            epoch++;
            buf_lines = 0;
            exp_pc    = {redirect_pc[63:2], 2'b00};
            exp_req   = {redirect_pc[63:3], 3'b000};
            clear_obs();
        end else begin
            if (hs) begin
                hs_q.push_back(out_pc);
                hs_cyc.push_back(cyc);
                hs_total++;
                if (exp_pc[2]) buf_lines--;
                exp_pc = exp_pc + 64'd4;
            end
            if (acc) begin
                last_due = (cyc + int'($urandom_range(lat_max, lat_min)) > last_due + 1) ?
                           cyc + int'($urandom_range(lat_max, lat_min)) : last_due + 1;
                memq.push_back('{addr: mem_req_addr, due: last_due, ep: epoch});
                out_cnt++;
                acc_total++;
                if (!cap_seen) begin
                    cap_req  = mem_req_addr;
                    cap_seen = 1'b1;
                end
                exp_req = exp_req + 64'd8;
            end
        end
        if (mem_resp_valid) begin
            out_cnt--;
            if (!redirect && rsp_ep == epoch) buf_lines++;
        end
        if (out_cnt > max_out_seen) max_out_seen = out_cnt;
        chk("outstanding_le_max", 64'(out_cnt <= MAX_OUT), 64'd1);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 64'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        out_ready      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("reset_out_valid", 64'(out_valid), 64'd0);
            chk("reset_req_addr", mem_req_addr, PC_START);
            @(posedge clock);
            #1;
            cyc++;
        end
        memq.delete();
        out_cnt      = 0;
        buf_lines    = 0;
        epoch        = 0;
        exp_pc       = PC_START;
        exp_req      = {PC_START[63:3], 3'b000};
        last_due     = cyc;
        acc_total    = 0;
        max_out_seen = 0;
        redir_req    = 1'b0;
        clear_obs();
        rst = 1'b1;
    endtask

    redir_vec_t vecs[4];

    initial begin
        int c0;
        vecs[0] = '{64'h0000_0000_8000_0104, 64'h0000_0000_8000_0100, 64'h0000_0000_8000_0104, 64'h0000_0000_8000_0108};
        vecs[1] = '{64'h0000_0000_1000_0000, 64'h0000_0000_1000_0000, 64'h0000_0000_1000_0000, 64'h0000_0000_1000_0004};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h0000_0000_2000_0007, 64'h0000_0000_2000_0000, 64'h0000_0000_2000_0004, 64'h0000_0000_2000_0008};

        // reset release with a 1-cycle memory and decode always ready
        do_reset();
        c0 = cyc;
        for (int k = 0; k < 20 && hs_q.size() < 3; k++) step();
        chk("boot_req0", cap_req, 64'h8000_0000);
        chk("boot_hs_cnt", 64'(hs_q.size() >= 3), 64'd1);
        if (hs_q.size() >= 3) begin
            chk("boot_pc0", hs_q[0], 64'h8000_0000);
            chk("boot_pc1", hs_q[1], 64'h8000_0004);
            chk("boot_pc2", hs_q[2], 64'h8000_0008);
            chk("boot_first_lat", 64'(hs_cyc[0] - c0), 64'd2);
            chk("boot_consecutive", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);
        end
        for (int k = 0; k < 10; k++) step();

        // table of redirect targets
        foreach (vecs[i]) begin
            redir_target  = vecs[i].target;
            redir_on_resp = 1'b0;
            redir_req     = 1'b1;
            step();
            for (int k = 0; k < 30 && hs_q.size() < 2; k++) step();
            chk("redir_hs_cnt", 64'(hs_q.size() >= 2), 64'd1);
            chk("redir_req_addr", cap_req, vecs[i].exp_req);
            if (hs_q.size() >= 2) begin
                chk("redir_first_pc", hs_q[0], vecs[i].exp_first);
                chk("redir_second_pc", hs_q[1], vecs[i].exp_second);
                chk("redir_latency", 64'(hs_cyc[0] - redir_cyc), 64'd3);
            end
            for (int k = 0; k < 6; k++) step();
        end

        // decode stalled for 20 cycles: exactly DEPTH lines buffered, then drained in order
        do_reset();
        p_out = 0;
        for (int k = 0; k < 20; k++) step();
        chk("stall_lines", 64'(acc_total), 64'(DEPTH));
        chk("stall_req_valid", 64'(mem_req_valid), 64'd0);
        p_out = 100;
        clear_obs();
        for (int k = 0; k < 2 * DEPTH; k++) step();
        chk("drain_cnt", 64'(hs_q.size()), 64'(2 * DEPTH));
        if (hs_q.size() == 2 * DEPTH) begin
            chk("drain_last_pc", hs_q[2 * DEPTH - 1], PC_START + 64'(4 * (2 * DEPTH - 1)));
        end

        // latency 5: outstanding limit is reached and never exceeded
        lat_min = 5;
        lat_max = 5;
        max_out_seen = 0;
        for (int k = 0; k < 60; k++) step();
        chk("lat5_max_out", 64'(max_out_seen), 64'(MAX_OUT));

        // redirect with MAX_OUT requests in flight: all stale responses dropped
        for (int k = 0; k < 20 && out_cnt != MAX_OUT; k++) step();
        chk("pre_redir_out", 64'(out_cnt), 64'(MAX_OUT));
        redir_target  = 64'h4000_0000;
        redir_req     = 1'b1;
        step();
        for (int k = 0; k < 40 && hs_q.size() < 1; k++) step();
        chk("drop_hs_cnt", 64'(hs_q.size() >= 1), 64'd1);
        if (hs_q.size() >= 1) chk("drop_first_pc", hs_q[0], 64'h4000_0000);

        // redirect in the same cycle as a response and a ready decode
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 10; k++) step();
        redir_target    = 64'h8000_0200;
        redir_on_resp   = 1'b1;
        redir_with_resp = 1'b0;
        redir_req       = 1'b1;
        for (int k = 0; k < 10 && redir_req; k++) step();
        redir_on_resp = 1'b0;
        chk("coinc_resp", 64'(redir_with_resp), 64'd1);
        for (int k = 0; k < 20 && hs_q.size() < 2; k++) step();
        chk("coinc_hs_cnt", 64'(hs_q.size() >= 2), 64'd1);
        if (hs_q.size() >= 2) begin
            chk("coinc_pc0", hs_q[0], 64'h8000_0200);
            chk("coinc_pc1", hs_q[1], 64'h8000_0204);
        end
        redir_req = 1'b0;

        // randomized traffic with random latency, backpressure and redirects
        lat_min = 1;
        lat_max = 6;
        p_ready = 70;
        p_out   = 60;
        p_redir = 30;
        hs_total = 0;
        for (int k = 0; k < 4000; k++) step();
        chk("random_progress", 64'(hs_total > 200), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with a line prefetch queue, replacing the single-PC, one-instruction-per-cycle fetch stage. It issues 64-bit-aligned line reads to instruction memory over a valid/ready request channel with multiple requests in flight. It buffers returned lines and unpacks them into 32-bit instructions for decode over a valid/ready handshake. Jump and branch redirects flush the queue and discard stale in-flight responses. It sits between the instruction-memory port and the decode stage.

## Interface
Parameters:
- PC_START, 64'h8000_0000: first fetch PC after reset; must be 4-byte aligned.
- DEPTH, 4: line-queue entries; power of two, ≥2.
- MAX_OUT, 2: maximum accepted-but-unanswered memory requests; 1..DEPTH.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  jump/branch taken; flush and restart at redirect_pc.
- redirect_pc  in  64  new PC; bits [1:0] ignored.
- mem_req_valid  out  1  line read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  64  line address, bits [2:0] always 0.
- mem_resp_valid  in  1  read data returned; in order; no backpressure; never in the same cycle as the matching request acceptance.
- mem_resp_data  in  64  line data; [31:0] = instruction at addr, [63:32] = instruction at addr+4.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts instruction.
- out_pc  out  64  PC of out_inst.
- out_inst  out  32  instruction word.

## Operation
- State: fetch_pc, outstanding count (0..MAX_OUT), drop count (0..MAX_OUT), pending-PC FIFO (MAX_OUT deep), line queue (DEPTH entries of {line_pc, data}), head slot bit.
- Request: mem_req_valid = !redirect && outstanding < MAX_OUT && (outstanding + queue occupancy) < DEPTH.
- mem_req_addr = {fetch_pc[63:3], 3'b0}.
- On accept: push fetch_pc to pending FIFO, outstanding+1, fetch_pc ← mem_req_addr + 8.
- Response with drop > 0: data discarded, drop−1, pending FIFO popped, outstanding−1.
- Response with drop = 0: pop pending PC p, write {p, data} to queue tail, outstanding−1. Credit rule guarantees the queue never overflows.
- Output: head entry h, slot s (reset/load to h.line_pc[2] when the entry becomes head).
  - out_pc = {h.line_pc[63:3], s, 2'b00}.
  - out_inst = s ? data[63:32] : data[31:0].
  - out_valid = queue non-empty && !redirect.
- On out_valid && out_ready:
  - s = 0: s ← 1.
  - s = 1: pop entry; next head's slot loads from its own line_pc[2].
- Redirect, which has priority over everything:
  - Queue emptied.
  - fetch_pc ← {redirect_pc[63:2], 2'b00}.
  - drop ← outstanding minus any response consumed in the same cycle.
  - Outstanding and pending FIFO keep tracking the in-flight requests, so dropped responses are still retired.
  - No request is issued and no output handshake occurs in a redirect cycle.
  - A response arriving in the redirect cycle is discarded.
- Redirect to a PC with bit 2 = 1: first line yields only the upper instruction.
- Simultaneous request accept and response: outstanding unchanged; FIFO push and pop both occur.
- fetch_pc wraps modulo 2^64.

## Timing
- Reset (rst low, asynchronous):
  - fetch_pc = PC_START; outstanding = drop = 0; queue empty; s = 0.
  - mem_req_valid may assert in the first cycle after rst deasserts.
  - out_valid = 0.
- Response data is registered into the queue; out_valid asserts the cycle after a written response.
- With a 1-cycle memory and no stall:
  - Redirect in cycle N: request at N+1, response at N+2, out_valid at N+3.
  - Steady-state throughput: one instruction per cycle.
- out_pc and out_inst are held stable while out_valid && !out_ready, unless redirect is asserted.

## Test plan
- Reset release, 1-cycle memory, out_ready=1 -> requests 0x8000_0000, 0x8000_0008, …; out_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 in consecutive cycles with correct halves.
- Redirect to 0x8000_0104 -> next request 0x8000_0100; first output pc 0x8000_0104 = data[63:32]; next 0x8000_0108.
- out_ready=0 for 20 cycles -> exactly DEPTH lines buffered, mem_req_valid low; after release, 2·DEPTH in-order instructions with no loss.
- Memory latency 5, MAX_OUT=2 -> never more than 2 unanswered requests; mem_req_valid drops at the limit.
- Redirect with 2 requests outstanding -> both responses discarded (drop 2→0); first output is the redirect target line.
- Redirect in the same cycle as mem_resp_valid and out_ready -> response discarded, no handshake, drop = outstanding−1; clean restart.
